sipo_frame_ctrl: RTL and testbench

Frame controller for the serial-in/parallel-out shift-register datapath. On a start pulse it captures exactly WIDTH serial bits from B, one per sclk edge, then presents the parallel word with a valid/ready handshake. It exports shift_en so an external SIPO register can be driven in lockstep with the internal capture register. It also flags frames lost because the consumer was too slow.

---
 rtl/sipo_frame_ctrl.sv | 130 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial-in/parallel-out frame controller with valid/ready output
//
// Captures WIDTH serial bits from B after a start request, one bit per rising
// sclk edge, then holds the parallel word on sQ under a valid/ready handshake.
//
// Ports:
//   sclk        in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   frame start request
//   B           in   serial data bit
//   shift_en    out  high while a bit is being captured (external SIPO enable)
//   busy        out  high while shifting or holding a frame
//   bit_cnt     out  bits captured so far in the current frame
//   sQ          out  parallel frame word
//   data_valid  out  sQ holds a complete, unaccepted frame
//   data_ready  in   consumer accepts sQ
//   overrun     out  sticky: start seen while an unaccepted frame was held

module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             B,
  output logic             shift_en,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] sQ,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] sr_shift;

  // Shift direction decides which end of sQ the first received bit lands in.
  always_comb begin
    if (LSB_FIRST) begin
      sr_shift = {B, sr_q[WIDTH-1:1]};
    end else begin
      sr_shift = {sr_q[WIDTH-2:0], B};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    sq_d      = sq_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        // The start edge itself does not sample B.
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        // start is ignored here: no restart and no overrun.
        sr_d = sr_shift;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the word including the bit sampled on this edge.
          sq_d    = sr_shift;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (data_ready) begin
          cnt_d = '0;
          if (start) begin
            // Back-to-back frame: go straight to shifting, busy never drops.
            state_d = SHIFT;
            sr_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          // Consumer too slow: the request is dropped and flagged.
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      sq_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      sq_q      <= sq_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign shift_en   = (state_q == SHIFT);
  assign busy       = (state_q != IDLE);
  assign data_valid = (state_q == HOLD);
  assign bit_cnt    = cnt_q;
  assign sQ         = sq_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - directed self-checking bench for sipo_frame_ctrl
//
// Two instances share all inputs: u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             B = 1'b0;
  logic             data_ready = 1'b0;

  logic             shift_en, busy, data_valid, overrun;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sQ;

  logic             m_shift_en, m_busy, m_data_valid, m_overrun;
  logic [CW-1:0]    m_bit_cnt;
  logic [WIDTH-1:0] m_sQ;

  int checks   = 0;
  int failures = 0;

  always #5 sclk = ~sclk;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) u_lsb (
    .sclk(sclk), .rst_n(rst_n), .start(start), .B(B),
    .shift_en(shift_en), .busy(busy), .bit_cnt(bit_cnt), .sQ(sQ),
    .data_valid(data_valid), .data_ready(data_ready), .overrun(overrun)
  );

  sipo_frame_ctrl #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) u_msb (
    .sclk(sclk), .rst_n(rst_n), .start(start), .B(B),
    .shift_en(m_shift_en), .busy(m_busy), .bit_cnt(m_bit_cnt), .sQ(m_sQ),
    .data_valid(m_data_valid), .data_ready(data_ready), .overrun(m_overrun)
  );

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Clean reset between scenarios (clears sticky overrun).
  task automatic do_reset();
    start = 1'b0; B = 1'b0; data_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Start edge followed by four bits; leaves the DUT in HOLD.
  task automatic run_frame(input logic [3:0] bits);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      B = bits[3-i];
      step();
    end
    B = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({shift_en, busy, data_valid, overrun, bit_cnt, sQ} !== '0) begin
      failures++;
      $display("FAIL reset_outputs act=%b%b%b%b cnt=%0d sQ=%b exp=all zero",
               shift_en, busy, data_valid, overrun, bit_cnt, sQ);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [CW-1:0] exp_cnt [4] = '{CW'(1), CW'(2), CW'(3), CW'(0)};
    logic [3:0] bits = 4'b1101;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (shift_en !== 1'b1 || busy !== 1'b1 || bit_cnt !== '0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_edge act se=%b busy=%b cnt=%0d dv=%b exp se=1 busy=1 cnt=0 dv=0",
               shift_en, busy, bit_cnt, data_valid);
    end
    for (int i = 0; i < 4; i++) begin
      B = bits[3-i];
      step();
      checks++;
      if (bit_cnt !== exp_cnt[i]) begin
        failures++;
        $display("FAIL bit_cnt[%0d] act=%0d exp=%0d", i, bit_cnt, exp_cnt[i]);
      end
      checks++;
      if (data_valid !== (i == 3) || shift_en !== (i != 3)) begin
        failures++;
        $display("FAIL shift_valid[%0d] act dv=%b se=%b exp dv=%b se=%b",
                 i, data_valid, shift_en, (i == 3), (i != 3));
      end
    end
    checks++;
    if (sQ !== 4'b1011) begin
      failures++;
      $display("FAIL lsb_word act=%b exp=1011", sQ);
    end
    checks++;
    if (m_sQ !== 4'b1101 || m_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL msb_word act=%b dv=%b exp=1101 dv=1", m_sQ, m_data_valid);
    end
    step();
    checks++;
    if (data_valid !== 1'b1 || sQ !== 4'b1011) begin
      failures++;
      $display("FAIL hold_stable act dv=%b sQ=%b exp dv=1 sQ=1011", data_valid, sQ);
    end
    data_ready = 1'b1; step(); data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || sQ !== 4'b1011) begin
      failures++;
      $display("FAIL accept_idle act dv=%b busy=%b sQ=%b exp dv=0 busy=0 sQ=1011",
               data_valid, busy, sQ);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bits = 4'b0010;
    do_reset();
    run_frame(4'b1101);
    data_ready = 1'b1; start = 1'b1;
    step();
    data_ready = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0 || shift_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_start act busy=%b dv=%b se=%b exp busy=1 dv=0 se=1",
               busy, data_valid, shift_en);
    end
    for (int i = 0; i < 4; i++) begin
      B = bits[3-i];
      step();
      checks++;
      if (busy !== 1'b1 || data_valid !== (i == 3)) begin
        failures++;
        $display("FAIL b2b_bit[%0d] act busy=%b dv=%b exp busy=1 dv=%b",
                 i, busy, data_valid, (i == 3));
      end
    end
    B = 1'b0;
    checks++;
    if (sQ !== 4'b0100 || m_sQ !== 4'b0010) begin
      failures++;
      $display("FAIL b2b_word act lsb=%b msb=%b exp lsb=0100 msb=0010", sQ, m_sQ);
    end
    data_ready = 1'b1; step(); data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    run_frame(4'b1101);
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || data_valid !== 1'b1 || shift_en !== 1'b0 || sQ !== 4'b1011) begin
      failures++;
      $display("FAIL overrun_set act ov=%b dv=%b se=%b sQ=%b exp ov=1 dv=1 se=0 sQ=1011",
               overrun, data_valid, shift_en, sQ);
    end
    step();
    checks++;
    if (overrun !== 1'b1 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky act ov=%b dv=%b exp ov=1 dv=1", overrun, data_valid);
    end
    data_ready = 1'b1; step(); data_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_after_accept act busy=%b dv=%b ov=%b exp busy=0 dv=0 ov=1",
               busy, data_valid, overrun);
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    B = 1'b1; step();
    B = 1'b1; step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({shift_en, busy, data_valid, overrun, bit_cnt, sQ} !== '0) begin
      failures++;
      $display("FAIL async_reset act se=%b busy=%b dv=%b ov=%b cnt=%0d sQ=%b exp all zero",
               shift_en, busy, data_valid, overrun, bit_cnt, sQ);
    end
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_aborts act busy=%b exp=0", busy);
    end
    run_frame(4'b0010);
    checks++;
    if (sQ !== 4'b0100 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_word act sQ=%b dv=%b exp sQ=0100 dv=1", sQ, data_valid);
    end
    data_ready = 1'b1; step(); data_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    B = 1'b1; step();
    B = 1'b0; start = 1'b1; step(); start = 1'b0;
    checks++;
    if (bit_cnt !== CW'(2)) begin
      failures++;
      $display("FAIL ignore_cnt2 act=%0d exp=2", bit_cnt);
    end
    B = 1'b1; step();
    checks++;
    if (bit_cnt !== CW'(3) || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_cnt3 act cnt=%0d dv=%b exp cnt=3 dv=0", bit_cnt, data_valid);
    end
    B = 1'b1; step(); B = 1'b0;
    checks++;
    if (data_valid !== 1'b1 || sQ !== 4'b1101 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ignore_done act dv=%b sQ=%b ov=%b exp dv=1 sQ=1101 ov=0",
               data_valid, sQ, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_overrun();
    test_mid_frame_reset();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
